spoofer_stream_ctrl: RTL and testbench

SPOOFER_STREAM_CTRL -- requirements
Module: spoofer_stream_ctrl

---
 rtl/spoofer_stream_ctrl_if.sv | 28 ++
 rtl/spoofer_stream_ctrl.sv | 162 ++++++++++++++++
 tb/tb_spoofer_stream_ctrl.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spoofer_stream_ctrl_if.sv
// Avalon-ST source bundle driven by spoofer_stream_ctrl (master) toward a sink (slave).
// Handshake: a beat transfers on any clock edge where out_valid && out_ready (readyLatency 0);
// while out_valid is high and out_ready is low the master holds out_data/out_sop/out_eop stable.
interface spoofer_stream_ctrl_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_sop;
  logic                  out_eop;

  modport master (
    output out_data,
    output out_valid,
    output out_sop,
    output out_eop,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_sop,
    input  out_eop,
    output out_ready
  );
endinterface

// File: rtl/spoofer_stream_ctrl.sv
// Reads a free-running spoofer counter and streams its values as fixed-length Avalon-ST packets.
// Optional packet counter output enabled by defining SPOOFER_STREAM_CTRL_PKTCNT_EN.
module spoofer_stream_ctrl #(
  parameter int DATA_WIDTH    = 32,
  parameter int PKT_LEN       = 16,
  parameter int SETTLE_CYCLES = 3,
  parameter int GAP_CYCLES    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] count_in,
  output logic                  rd_strobe,
  output logic                  busy,
  output logic [1:0]            fsm_state,
`ifdef SPOOFER_STREAM_CTRL_PKTCNT_EN
  output logic [15:0]           pkt_count,
`endif
  spoofer_stream_ctrl_if.master st
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    PRESENT = 2'd2,
    GAP     = 2'd3
  } state_t;

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int BW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES);
  localparam logic [BW-1:0] LAST_BEAT   = BW'(PKT_LEN - 1);
  localparam logic [7:0]    GAP_LOAD    = 8'(GAP_CYCLES);

  if (SETTLE_CYCLES < 3 || PKT_LEN < 1 || PKT_LEN > 65535 ||
      GAP_CYCLES < 0 || GAP_CYCLES > 255) begin : g_param_check
    $error("spoofer_stream_ctrl: illegal parameter combination");
  end

  state_t                state, state_n;
  logic [SW-1:0]         settle_cnt, settle_n;
  logic [7:0]            gap_cnt, gap_n;
  logic [BW-1:0]         beat_idx, beat_n;
  logic [DATA_WIDTH-1:0] data_q, data_n;
  logic                  valid_q, valid_n;
  logic                  sop_q, sop_n;
  logic                  eop_q, eop_n;
  logic                  strobe_q, strobe_n;
  logic                  busy_q, busy_n;
  logic                  accept;

  assign accept = valid_q & st.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      settle_cnt <= '0;
      gap_cnt    <= '0;
      beat_idx   <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      sop_q      <= 1'b0;
      eop_q      <= 1'b0;
      strobe_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state      <= state_n;
      settle_cnt <= settle_n;
      gap_cnt    <= gap_n;
      beat_idx   <= beat_n;
      data_q     <= data_n;
      valid_q    <= valid_n;
      sop_q      <= sop_n;
      eop_q      <= eop_n;
      strobe_q   <= strobe_n;
      busy_q     <= busy_n;
    end
  end

  always_comb begin
    state_n  = state;
    settle_n = settle_cnt;
    gap_n    = gap_cnt;
    beat_n   = beat_idx;
    data_n   = data_q;
    valid_n  = valid_q;
    sop_n    = sop_q;
    eop_n    = eop_q;
    strobe_n = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          state_n  = SETTLE;
          settle_n = SETTLE_LOAD;
        end
      end
      SETTLE: begin
        settle_n = settle_cnt - SW'(1);
        // count_in has had time to settle after the previous strobe; capture it now.
        if (settle_cnt == SW'(1)) begin
          data_n  = count_in;
          valid_n = 1'b1;
          sop_n   = (beat_idx == '0);
          eop_n   = (beat_idx == LAST_BEAT);
          state_n = PRESENT;
        end
      end
      PRESENT: begin
        if (accept) begin
          valid_n  = 1'b0;
          sop_n    = 1'b0;
          eop_n    = 1'b0;
          strobe_n = 1'b1;
          if (eop_q) begin
            beat_n = '0;
            if (GAP_CYCLES == 0) begin
              state_n  = enable ? SETTLE : IDLE;
              settle_n = enable ? SETTLE_LOAD : '0;
            end else begin
              state_n = GAP;
              gap_n   = GAP_LOAD;
            end
          end else begin
            beat_n   = beat_idx + BW'(1);
            state_n  = SETTLE;
            settle_n = SETTLE_LOAD;
          end
        end
      end
      GAP: begin
        if (gap_cnt <= 8'd1) begin
          gap_n    = '0;
          state_n  = enable ? SETTLE : IDLE;
          settle_n = enable ? SETTLE_LOAD : '0;
        end else begin
          gap_n = gap_cnt - 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

`ifdef SPOOFER_STREAM_CTRL_PKTCNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_count <= '0;
    end else if (accept && eop_q) begin
      pkt_count <= pkt_count + 16'd1;
    end
  end
`endif

  assign st.out_data  = data_q;
  assign st.out_valid = valid_q;
  assign st.out_sop   = sop_q;
  assign st.out_eop   = eop_q;
  assign rd_strobe    = strobe_q;
  assign busy         = busy_q;
  assign fsm_state    = state;

endmodule

// File: tb/tb_spoofer_stream_ctrl.sv
// Bench for spoofer_stream_ctrl: counter models attached, scoreboard of expected beats.
// Also runs a second instance with PKT_LEN=1 and GAP_CYCLES=0.
module tb_spoofer_stream_ctrl;
  localparam int DW = 8;
  localparam int PL = 4;
  localparam int SC = 3;
  localparam int GC = 4;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_GAP  = 2'd3;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [DW-1:0] cnt;
  logic          rd_strobe;
  logic          busy;
  logic [1:0]    fsm_state;
  logic          preload_en;
  logic [DW-1:0] preload_val;

  logic          en1;
  logic [DW-1:0] cnt1;
  logic          rd1;
  logic          busy1;
  logic [1:0]    fsm1;
`ifdef SPOOFER_STREAM_CTRL_PKTCNT_EN
  logic [15:0]   pkt_count;
  logic [15:0]   pkt_count1;
`endif

  spoofer_stream_ctrl_if #(.DATA_WIDTH(DW)) st ();
  spoofer_stream_ctrl_if #(.DATA_WIDTH(DW)) st1 ();

  spoofer_stream_ctrl #(
    .DATA_WIDTH(DW), .PKT_LEN(PL), .SETTLE_CYCLES(SC), .GAP_CYCLES(GC)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .count_in(cnt),
    .rd_strobe(rd_strobe), .busy(busy), .fsm_state(fsm_state),
`ifdef SPOOFER_STREAM_CTRL_PKTCNT_EN
    .pkt_count(pkt_count),
`endif
    .st(st)
  );

  spoofer_stream_ctrl #(
    .DATA_WIDTH(DW), .PKT_LEN(1), .SETTLE_CYCLES(SC), .GAP_CYCLES(0)
  ) dut1 (
    .clk(clk), .rst(rst), .enable(en1), .count_in(cnt1),
    .rd_strobe(rd1), .busy(busy1), .fsm_state(fsm1),
`ifdef SPOOFER_STREAM_CTRL_PKTCNT_EN
    .pkt_count(pkt_count1),
`endif
    .st(st1)
  );

  // ---------------- clock / reset / counter models
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst)             cnt <= '0;
    else if (preload_en) cnt <= preload_val;
    else if (rd_strobe)  cnt <= cnt + 1'b1;
  end

  always @(posedge clk) begin
    if (rst)      cnt1 <= '0;
    else if (rd1) cnt1 <= cnt1 + 1'b1;
  end

  // ---------------- scoreboard
  logic [DW+1:0] exp_q[$];
  logic [DW+1:0] mon_exp;
  logic [DW-1:0] ref_val;
  int total = 0;
  int bad = 0;
  int accepted = 0;
  int strobes = 0;
  int low_run = 1000;

  always @(negedge clk) begin
    if (!rst && st.out_valid && st.out_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL beat_unexpected: got data=%0d sop=%0b eop=%0b, expected no beat",
                 st.out_data, st.out_sop, st.out_eop);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({st.out_sop, st.out_eop, st.out_data} !== mon_exp) begin
          bad++;
          $display("FAIL beat: got sop=%0b eop=%0b data=%0d, expected sop=%0b eop=%0b data=%0d",
                   st.out_sop, st.out_eop, st.out_data, mon_exp[DW+1], mon_exp[DW], mon_exp[DW-1:0]);
        end
      end
      accepted++;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      low_run = 1000;
    end else if (rd_strobe) begin
      total++;
      strobes++;
      if (low_run < SC) begin
        bad++;
        $display("FAIL strobe_spacing: got %0d low cycles, expected >= %0d", low_run, SC);
      end
      low_run = 0;
    end else begin
      low_run++;
    end
  end

  // ---------------- driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_packet();
    for (int i = 0; i < PL; i++) begin
      exp_q.push_back({(i == 0), (i == PL - 1), ref_val});
      ref_val = ref_val + 1'b1;
    end
  endtask

  task automatic wait_accepted(input int target, input int budget, output bit ok);
    int c = 0;
    ok = 1'b1;
    while (accepted < target) begin
      if (c >= budget) begin
        ok = 1'b0;
        return;
      end
      tick();
      c++;
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    int c = 0;
    ok = 1'b1;
    while (fsm_state != S_IDLE) begin
      if (c >= budget) begin
        ok = 1'b0;
        return;
      end
      tick();
      c++;
    end
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    int c = 0;
    ok = 1'b1;
    while (st.out_valid !== 1'b1) begin
      if (c >= budget) begin
        ok = 1'b0;
        return;
      end
      tick();
      c++;
    end
  endtask

  // ---------------- tests
  task automatic test_reset();
    rst = 1'b1;
    enable = 1'b0;
    st.out_ready = 1'b0;
    repeat (3) tick();
    total += 7;
    if (st.out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %0b expected 0", st.out_valid); end
    if (st.out_sop !== 1'b0) begin bad++; $display("FAIL rst_sop: got %0b expected 0", st.out_sop); end
    if (st.out_eop !== 1'b0) begin bad++; $display("FAIL rst_eop: got %0b expected 0", st.out_eop); end
    if (rd_strobe !== 1'b0) begin bad++; $display("FAIL rst_strobe: got %0b expected 0", rd_strobe); end
    if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %0b expected 0", busy); end
    if (st.out_data !== '0) begin bad++; $display("FAIL rst_data: got %0d expected 0", st.out_data); end
    if (fsm_state !== S_IDLE) begin bad++; $display("FAIL rst_state: got %0d expected 0", fsm_state); end
    rst = 1'b0;
    repeat (2) tick();
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy: got %0b expected 0", busy); end
    exp_q.delete();
    ref_val = '0;
  endtask

  task automatic test_basic();
    int acc0 = accepted;
    int str0 = strobes;
    int gap_seen = 0;
    int c = 0;
    push_packet();
    push_packet();
    enable = 1'b1;
    st.out_ready = 1'b1;
    while (accepted < acc0 + 8 && c < 300) begin
      tick();
      c++;
      if (fsm_state == S_GAP) gap_seen++;
      if (accepted >= acc0 + 5) enable = 1'b0;
    end
    total++;
    if (accepted != acc0 + 8) begin bad++; $display("FAIL basic_timeout: got %0d beats expected 8", accepted - acc0); end
    c = 0;
    while (fsm_state != S_IDLE && c < 50) begin
      tick();
      c++;
      if (fsm_state == S_GAP) gap_seen++;
    end
    total += 4;
    if (fsm_state !== S_IDLE) begin bad++; $display("FAIL basic_idle: got state %0d expected 0", fsm_state); end
    if (gap_seen != 2 * GC) begin bad++; $display("FAIL basic_gap: got %0d gap cycles expected %0d", gap_seen, 2 * GC); end
    if (strobes - str0 != 8) begin bad++; $display("FAIL basic_strobes: got %0d expected 8", strobes - str0); end
    if (exp_q.size() != 0) begin bad++; $display("FAIL basic_left: got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    int acc0 = accepted;
    bit ok;
    logic [DW-1:0] hold_exp;
    hold_exp = ref_val + 8'd2;
    push_packet();
    enable = 1'b1;
    st.out_ready = 1'b1;
    wait_accepted(acc0 + 2, 100, ok);
    st.out_ready = 1'b0;
    total++;
    if (!ok) begin bad++; $display("FAIL bp_start: got %0d beats expected 2", accepted - acc0); end
    wait_valid(20, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL bp_valid: got valid=0 expected 1"); end
    for (int h = 0; h < 10; h++) begin
      total += 3;
      if (st.out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid: got %0b expected 1", st.out_valid); end
      if (st.out_data !== hold_exp) begin bad++; $display("FAIL bp_hold_data: got %0d expected %0d", st.out_data, hold_exp); end
      if (rd_strobe !== 1'b0) begin bad++; $display("FAIL bp_hold_strobe: got %0b expected 0", rd_strobe); end
      tick();
    end
    st.out_ready = 1'b1;
    tick();
    total += 2;
    if (rd_strobe !== 1'b1) begin bad++; $display("FAIL bp_strobe_on: got %0b expected 1", rd_strobe); end
    if (st.out_valid !== 1'b0) begin bad++; $display("FAIL bp_valid_clear: got %0b expected 0", st.out_valid); end
    tick();
    total++;
    if (rd_strobe !== 1'b0) begin bad++; $display("FAIL bp_strobe_off: got %0b expected 0", rd_strobe); end
    enable = 1'b0;
    wait_idle(100, ok);
    total += 2;
    if (!ok) begin bad++; $display("FAIL bp_idle: got state %0d expected 0", fsm_state); end
    if (exp_q.size() != 0) begin bad++; $display("FAIL bp_left: got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_enable_drop();
    int acc0 = accepted;
    int busy_cycles = 0;
    int stray = 0;
    bit ok;
    push_packet();
    enable = 1'b1;
    st.out_ready = 1'b1;
    wait_accepted(acc0 + 2, 100, ok);
    enable = 1'b0;
    wait_accepted(acc0 + 4, 100, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL drop_complete: got %0d beats expected 4", accepted - acc0); end
    while (busy === 1'b1 && busy_cycles < 50) begin
      busy_cycles++;
      tick();
    end
    total++;
    if (busy_cycles != GC) begin bad++; $display("FAIL drop_busy: got %0d busy cycles expected %0d", busy_cycles, GC); end
    repeat (20) begin
      if (rd_strobe !== 1'b0 || st.out_valid !== 1'b0 || fsm_state !== S_IDLE) stray++;
      tick();
    end
    total += 2;
    if (stray != 0) begin bad++; $display("FAIL drop_quiet: got %0d active cycles expected 0", stray); end
    if (exp_q.size() != 0) begin bad++; $display("FAIL drop_left: got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_wrap();
    int acc0 = accepted;
    bit ok;
    preload_val = 8'hFE;
    preload_en = 1'b1;
    tick();
    preload_en = 1'b0;
    ref_val = 8'hFE;
    push_packet();
    enable = 1'b1;
    st.out_ready = 1'b1;
    wait_accepted(acc0 + 1, 100, ok);
    enable = 1'b0;
    wait_accepted(acc0 + 4, 100, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL wrap_timeout: got %0d beats expected 4", accepted - acc0); end
    wait_idle(50, ok);
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL wrap_left: got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_single_beat();
    logic [DW-1:0] exp1 = '0;
    int beats = 0;
    st1.out_ready = 1'b1;
    en1 = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (st1.out_valid === 1'b1) begin
        total++;
        if ({st1.out_sop, st1.out_eop, st1.out_data} !== {2'b11, exp1}) begin
          bad++;
          $display("FAIL single_beat: got sop=%0b eop=%0b data=%0d expected sop=1 eop=1 data=%0d",
                   st1.out_sop, st1.out_eop, st1.out_data, exp1);
        end
        exp1 = exp1 + 1'b1;
        beats++;
      end
    end
    en1 = 1'b0;
    total++;
    if (beats != 15) begin bad++; $display("FAIL single_count: got %0d beats expected 15", beats); end
  endtask

  task automatic test_reset_mid();
    int acc0 = accepted;
    bit ok;
    push_packet();
    enable = 1'b1;
    st.out_ready = 1'b1;
    wait_accepted(acc0 + 2, 100, ok);
    st.out_ready = 1'b0;
    wait_valid(20, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL rmid_valid: got valid=0 expected 1"); end
    rst = 1'b1;
    tick();
    total += 7;
    if (st.out_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid0: got %0b expected 0", st.out_valid); end
    if (st.out_sop !== 1'b0) begin bad++; $display("FAIL rmid_sop: got %0b expected 0", st.out_sop); end
    if (st.out_eop !== 1'b0) begin bad++; $display("FAIL rmid_eop: got %0b expected 0", st.out_eop); end
    if (rd_strobe !== 1'b0) begin bad++; $display("FAIL rmid_strobe: got %0b expected 0", rd_strobe); end
    if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy: got %0b expected 0", busy); end
    if (st.out_data !== '0) begin bad++; $display("FAIL rmid_data: got %0d expected 0", st.out_data); end
    if (fsm_state !== S_IDLE) begin bad++; $display("FAIL rmid_state: got %0d expected 0", fsm_state); end
    exp_q.delete();
    ref_val = '0;
    rst = 1'b0;
    acc0 = accepted;
    push_packet();
    st.out_ready = 1'b1;
    wait_accepted(acc0 + 1, 100, ok);
    enable = 1'b0;
    wait_accepted(acc0 + 4, 100, ok);
    wait_idle(50, ok);
    total += 2;
    if (accepted != acc0 + 4) begin bad++; $display("FAIL rmid_after: got %0d beats expected 4", accepted - acc0); end
    if (exp_q.size() != 0) begin bad++; $display("FAIL rmid_left: got %0d pending expected 0", exp_q.size()); end
  endtask

`ifdef SPOOFER_STREAM_CTRL_PKTCNT_EN
  task automatic test_pkt_count();
    int acc0;
    bit ok;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (pkt_count !== 16'd0) begin bad++; $display("FAIL pkt_rst0: got %0d expected 0", pkt_count); end
    exp_q.delete();
    ref_val = '0;
    acc0 = accepted;
    push_packet();
    push_packet();
    push_packet();
    enable = 1'b1;
    st.out_ready = 1'b1;
    wait_accepted(acc0 + 9, 300, ok);
    enable = 1'b0;
    wait_accepted(acc0 + 12, 100, ok);
    wait_idle(50, ok);
    total++;
    if (pkt_count !== 16'd3) begin bad++; $display("FAIL pkt_count: got %0d expected 3", pkt_count); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (pkt_count !== 16'd0) begin bad++; $display("FAIL pkt_rst: got %0d expected 0", pkt_count); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish within 200000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    enable = 1'b0;
    en1 = 1'b0;
    preload_en = 1'b0;
    preload_val = '0;
    ref_val = '0;
    st.out_ready = 1'b0;
    st1.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_enable_drop();
    test_wrap();
    test_single_beat();
    test_reset_mid();
`ifdef SPOOFER_STREAM_CTRL_PKTCNT_EN
    test_pkt_count();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
